instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction fetch and phase sequencer sitting directly downstream of the program counter. It takes the counter's 5-bit `address`, reads a 32-entry, 8-bit program store, and steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK. It emits per-phase strobes for the register file and ALU. A new `address` value always restarts the sequence, so 3-cycle and 4-cycle counter slots both work without the sequencer knowing the slot length.

## Interface
- `ADDR_W`, 5, program address width
- `INSTR_W`, 8, instruction width; field layout below is fixed for 8
- `DEPTH`, 32, program store entries (2**ADDR_W)
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, synchronous, active-low
- `address` in ADDR_W: current program address from the program counter
- `prog_we` in 1: program store write enable
- `prog_addr` in ADDR_W: program store write address
- `prog_data` in INSTR_W: program store write data
- `instr` out INSTR_W: latched instruction
- `opcode` out 3: `instr[7:5]`
- `rd` out 2: `instr[4:3]`
- `rs` out 2: `instr[2:1]`
- `mode` out 1: `instr[0]`
- `phase` out 3: current state encoding
- `rf_re` out 1: register-file read strobe
- `alu_en` out 1: ALU enable
- `rf_we` out 1: register-file write strobe
- `wb_lost` out 1: one-cycle pulse; a writing instruction was cut off before WRITEBACK
- `halt` out 1: sticky halt flag

## Operation
- Opcodes:
  - 000 NOP; 111 HALT. These are non-writing.
  - 001 ADD, 010 SUB, 011 AND, 100 OR, 101 LDI, 110 MOV. These are writing.
- States and encoding: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, WAIT=4, HALTED=5.
- `addr_q` holds the last accepted address. A change is detected when the sampled `address` differs from `addr_q`. On a change:
  - `addr_q` ← `address`.
  - next state = FETCH. This takes priority over every normal transition except HALTED.
- Normal transitions:
  - FETCH→DECODE; `instr` ← store[`address`] at the end of FETCH.
  - DECODE→EXECUTE.
  - EXECUTE→WRITEBACK. If the opcode is HALT, go to HALTED instead.
  - WRITEBACK→WAIT.
  - WAIT→WAIT.
- Strobes are Moore outputs decoded from state and `instr`:
  - `rf_re`=1 in DECODE when the opcode is not NOP/HALT.
  - `alu_en`=1 in EXECUTE when the opcode is not NOP/HALT.
  - `rf_we`=1 in WRITEBACK for writing opcodes only.
- `wb_lost` is a registered pulse. It is 1 in the cycle after a change is detected while the state was EXECUTE with a writing opcode.
- HALTED:
  - Absorbing; only `rst` leaves it.
  - `halt`=1 from the cycle HALTED is entered onward.
  - All strobes are 0 and address changes are ignored.
- Program store:
  - Initialised to all zero (NOP) and not cleared by `rst`.
  - `prog_we` writes at the clock edge, whether or not the block is halted.
  - If FETCH and a write target the same entry in the same cycle, `instr` gets the old data (read-before-write).

## Timing
- Reset, applied when `rst`=0 at an edge:
  - state=FETCH, `addr_q`=0, `instr`=0, `wb_lost`=0, `halt`=0.
  - `rf_re`/`alu_en`/`rf_we`=0.
  - `opcode`/`rd`/`rs`/`mode`=0.
- Reset mid-operation discards the current instruction. It has priority over change detection.
- The counter updates `address` after an edge. The sequencer sees the new value at the next edge, so FETCH occupies the cycle after that edge.
- 4-cycle slot: FETCH, DECODE, EXECUTE, WRITEBACK, one strobe per cycle.
- 3-cycle slot: FETCH, DECODE, EXECUTE, then FETCH again. WRITEBACK is never reached; writing opcodes produce `wb_lost`.
- Slots of 5 or more cycles: remain in WAIT with all strobes 0.
- `instr` is valid from the first DECODE cycle until the next FETCH completes.
- Address wrap from 31 to 0 is an ordinary change.

## Test plan
- Reset check:
  - Stimulus: hold `rst`=0 for 2 cycles with `address`=7.
  - Response: every output is 0 and `phase`=0.
  - After release, the change 0→7 is detected and FETCH runs, with the store at NOP.
- 4-cycle ADD:
  - Stimulus: store[4]=0x2A (ADD rd=1 rs=1 mode=0); step `address` 3→4 and hold 4 cycles.
  - Response: `rf_re`, `alu_en`, `rf_we` each pulse once in consecutive cycles; `rd`=1, `rs`=1; `wb_lost`=0.
- 3-cycle slot with MOV:
  - Stimulus: store[2]=0xC4; hold `address`=2 for 3 cycles, then change to 3.
  - Response: `rf_we` never asserts; `wb_lost`=1 for exactly one cycle after the change.
- HALT:
  - Stimulus: store[5]=0xE0; hold `address`=5, then keep changing `address`.
  - Response: `halt`=1 two cycles after DECODE, `phase`=5, strobes stay 0 until `rst`=0.
- Reset mid-instruction:
  - Stimulus: assert `rst` during the EXECUTE of ADD.
  - Response: `alu_en` drops at that edge and no `rf_we` follows.
- Write collision:
  - Stimulus: store[9]=0x00; in the FETCH cycle for address 9, write 0x2A to entry 9.
  - Response: `instr`=0x00, and the next fetch of entry 9 returns 0x2A.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction fetch and phase sequencer.
// Reads a small program store at the address supplied by the program counter
// and steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK,
// emitting one strobe per phase. Any new address restarts the sequence, so the
// block works with counter slots of any length without knowing that length.
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic               mode,
  output logic [2:0]         phase,
  output logic               rf_re,
  output logic               alu_en,
  output logic               rf_we,
  output logic               wb_lost,
  output logic               halt
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    WAIT      = 3'd4,
    HALTED    = 3'd5
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t              state;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [INSTR_W-1:0]  store [DEPTH] = '{default: '0};
  logic                changed;
  logic                writing;
  logic                load_instr;
  logic                lost_d;

  // Fixed field layout of the 8-bit instruction word.
  assign opcode  = instr[7:5];
  assign rd      = instr[4:3];
  assign rs      = instr[2:1];
  assign mode    = instr[0];
  assign phase   = state;

  // Every opcode other than NOP and HALT reads, computes and writes back.
  assign writing = (opcode != OP_NOP) && (opcode != OP_HALT);
  assign changed = (address != addr_q);

  // Program store write port; independent of reset and of the halted state.
  // Reads happen on the same edge, so a colliding fetch sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we)
      store[prog_addr] <= prog_data;
  end

  // Next-state, restart and strobe decode; an address change overrides
  // every normal transition, but nothing leaves HALTED except reset.
  always_comb begin
    state_d    = state;
    load_instr = 1'b0;
    lost_d     = 1'b0;
    rf_re      = 1'b0;
    alu_en     = 1'b0;
    rf_we      = 1'b0;

    if (state == HALTED) begin
      state_d = HALTED;
    end else if (changed) begin
      state_d = FETCH;
      lost_d  = (state == EXECUTE) && writing;
    end else begin
      unique case (state)
        FETCH: begin
          state_d    = DECODE;
          load_instr = 1'b1;
        end
        DECODE:    state_d = EXECUTE;
        EXECUTE:   state_d = (opcode == OP_HALT) ? HALTED : WRITEBACK;
        WRITEBACK: state_d = WAIT;
        WAIT:      state_d = WAIT;
        default:   state_d = FETCH;
      endcase
    end

    rf_re  = (state == DECODE)    && writing;
    alu_en = (state == EXECUTE)   && writing;
    rf_we  = (state == WRITEBACK) && writing;
  end

  // State, accepted address, instruction latch and flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= FETCH;
      addr_q  <= '0;
      instr   <= '0;
      wb_lost <= 1'b0;
      halt    <= 1'b0;
    end else begin
      state   <= state_d;
      wb_lost <= lost_d;
      if (state != HALTED && changed)
        addr_q <= address;
      if (load_instr)
        instr <= store[address];
      if (state_d == HALTED)
        halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer. Inputs change 1 ns after a rising
// edge and outputs are compared at that same point, well away from the edge.
// Status vectors are {phase, rf_re, alu_en, rf_we, wb_lost, halt}.
module tb_instr_sequencer;

  logic       clk;
  logic       rst;
  logic [4:0] address;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] instr;
  logic [2:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       mode;
  logic [2:0] phase;
  logic       rf_re;
  logic       alu_en;
  logic       rf_we;
  logic       wb_lost;
  logic       halt;

  int n_vec  = 0;
  int n_fail = 0;

  instr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .instr     (instr),
    .opcode    (opcode),
    .rd        (rd),
    .rs        (rs),
    .mode      (mode),
    .phase     (phase),
    .rf_re     (rf_re),
    .alu_en    (alu_en),
    .rf_we     (rf_we),
    .wb_lost   (wb_lost),
    .halt      (halt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_store(input logic [4:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    address = 5'd7;
    prog_we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      prog_addr = 5'(i);
      prog_data = 8'h00;
      step();
    end
    prog_we = 1'b0;
    step();
    n_vec++;
    if ({instr, opcode, rd, rs, mode, phase, rf_re, alu_en, rf_we, wb_lost, halt} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h",
               {instr, opcode, rd, rs, mode, phase, rf_re, alu_en, rf_we, wb_lost, halt}, 24'h0);
    end
    rst = 1'b1;
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd0, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_fetch7: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd0, 5'b00000});
    end
    step();
    n_vec++;
    if ({instr, phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {8'h00, 3'd1, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_decode_nop: got %h want %h",
               {instr, phase, rf_re, alu_en, rf_we, wb_lost, halt}, {8'h00, 3'd1, 5'b00000});
    end
    step();
    step();
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd4, 5'b00000}) begin
      n_fail++;
      $display("FAIL reset_wait: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd4, 5'b00000});
    end
  endtask

  task automatic test_add_4cycle();
    write_store(5'd4, 8'h2A);
    address = 5'd3;
    step();
    address = 5'd4;
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd0, 5'b00000}) begin
      n_fail++;
      $display("FAIL add_fetch: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd0, 5'b00000});
    end
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd1, 5'b10000}) begin
      n_fail++;
      $display("FAIL add_decode: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd1, 5'b10000});
    end
    n_vec++;
    if ({instr, opcode, rd, rs, mode} !== {8'h2A, 3'd1, 2'd1, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL add_fields: got %h want %h", {instr, opcode, rd, rs, mode}, {8'h2A, 3'd1, 2'd1, 2'd1, 1'b0});
    end
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd2, 5'b01000}) begin
      n_fail++;
      $display("FAIL add_execute: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd2, 5'b01000});
    end
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd3, 5'b00100}) begin
      n_fail++;
      $display("FAIL add_writeback: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd3, 5'b00100});
    end
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd4, 5'b00000}) begin
      n_fail++;
      $display("FAIL add_wait: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd4, 5'b00000});
    end
  endtask

  task automatic test_mov_3cycle();
    write_store(5'd2, 8'hC4);
    address = 5'd2;
    step();
    step();
    n_vec++;
    if ({instr, phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {8'hC4, 3'd1, 5'b10000}) begin
      n_fail++;
      $display("FAIL mov_decode: got %h want %h",
               {instr, phase, rf_re, alu_en, rf_we, wb_lost, halt}, {8'hC4, 3'd1, 5'b10000});
    end
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd2, 5'b01000}) begin
      n_fail++;
      $display("FAIL mov_execute: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd2, 5'b01000});
    end
    address = 5'd3;
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd0, 5'b00010}) begin
      n_fail++;
      $display("FAIL mov_wb_lost: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd0, 5'b00010});
    end
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd1, 5'b00000}) begin
      n_fail++;
      $display("FAIL mov_lost_clears: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd1, 5'b00000});
    end
    step();
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd3, 5'b00000}) begin
      n_fail++;
      $display("FAIL mov_next_nop_wb: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd3, 5'b00000});
    end
  endtask

  task automatic test_reset_mid();
    address = 5'd4;
    step();
    step();
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd2, 5'b01000}) begin
      n_fail++;
      $display("FAIL mid_execute: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd2, 5'b01000});
    end
    rst = 1'b0;
    step();
    n_vec++;
    if ({instr, phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {8'h00, 3'd0, 5'b00000}) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want %h",
               {instr, phase, rf_re, alu_en, rf_we, wb_lost, halt}, {8'h00, 3'd0, 5'b00000});
    end
    rst     = 1'b1;
    address = 5'd0;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_vec++;
      if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'(i), 5'b00000}) begin
        n_fail++;
        $display("FAIL mid_no_wb[%0d]: got %b want %b", i, {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'(i), 5'b00000});
      end
    end
  endtask

  task automatic test_collision();
    write_store(5'd9, 8'h00);
    address = 5'd9;
    step();
    prog_we   = 1'b1;
    prog_addr = 5'd9;
    prog_data = 8'h2A;
    step();
    prog_we = 1'b0;
    n_vec++;
    if ({instr, phase, rf_re} !== {8'h00, 3'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL collide_old: got %h want %h", {instr, phase, rf_re}, {8'h00, 3'd1, 1'b0});
    end
    address = 5'd8;
    step();
    address = 5'd9;
    step();
    step();
    n_vec++;
    if ({instr, phase, rf_re} !== {8'h2A, 3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL collide_new: got %h want %h", {instr, phase, rf_re}, {8'h2A, 3'd1, 1'b1});
    end
  endtask

  task automatic test_wrap();
    address = 5'd31;
    step();
    step();
    address = 5'd0;
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd0, 5'b00000}) begin
      n_fail++;
      $display("FAIL wrap_fetch: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd0, 5'b00000});
    end
    step();
    n_vec++;
    if ({instr, phase} !== {8'h00, 3'd1}) begin
      n_fail++;
      $display("FAIL wrap_decode: got %h want %h", {instr, phase}, {8'h00, 3'd1});
    end
  endtask

  task automatic test_halt();
    logic [4:0] addr_seq [4];
    addr_seq = '{5'd6, 5'd0, 5'd31, 5'd4};
    write_store(5'd5, 8'hE0);
    address = 5'd5;
    step();
    step();
    n_vec++;
    if ({opcode, phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd7, 3'd1, 5'b00000}) begin
      n_fail++;
      $display("FAIL halt_decode: got %b want %b",
               {opcode, phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd7, 3'd1, 5'b00000});
    end
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd2, 5'b00000}) begin
      n_fail++;
      $display("FAIL halt_execute: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd2, 5'b00000});
    end
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd5, 5'b00001}) begin
      n_fail++;
      $display("FAIL halt_enter: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd5, 5'b00001});
    end
    for (int i = 0; i < 4; i++) begin
      address = addr_seq[i];
      if (i == 0) begin
        prog_we   = 1'b1;
        prog_addr = 5'd6;
        prog_data = 8'h2A;
      end
      step();
      prog_we = 1'b0;
      step();
      n_vec++;
      if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd5, 5'b00001}) begin
        n_fail++;
        $display("FAIL halt_sticky[%0d]: got %b want %b", i, {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd5, 5'b00001});
      end
    end
    rst     = 1'b0;
    address = 5'd6;
    step();
    n_vec++;
    if ({phase, rf_re, alu_en, rf_we, wb_lost, halt} !== {3'd0, 5'b00000}) begin
      n_fail++;
      $display("FAIL halt_reset: got %b want %b", {phase, rf_re, alu_en, rf_we, wb_lost, halt}, {3'd0, 5'b00000});
    end
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if ({instr, phase, rf_re, halt} !== {8'h2A, 3'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_write_kept: got %h want %h", {instr, phase, rf_re, halt}, {8'h2A, 3'd1, 1'b1, 1'b0});
    end
  endtask

  // Scenario sequence; each task leaves the DUT out of reset for the next.
  initial begin
    rst       = 1'b0;
    address   = 5'd0;
    prog_we   = 1'b0;
    prog_addr = 5'd0;
    prog_data = 8'h00;
    test_reset();
    test_add_4cycle();
    test_mov_3cycle();
    test_reset_mid();
    test_collision();
    test_wrap();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
